key_debounce: RTL and testbench
===============================

Name: key_debounce

Overview:
- Upstream conditioning stage for the push-button counter/7-seg block.
- Synchronises a raw, bouncing, active-low board key (KEY0) into the system clock domain and debounces it.
- Emits a clean debounced level plus single-cycle press and release pulses. The downstream counter uses `key_press` as its count enable, so it no longer clocks on the raw key.

Parameters:
- DB_CYCLES, 1_000_000, consecutive stable synchronised samples needed to accept a level change (20 ms at 50 MHz); legal range 2..2^24-1.
- KEY_ACTIVE_LOW, 1, 1 = raw key reads 0 when pressed; 0 = active-high key.
- REPEAT_DELAY, 25_000_000, hold cycles from `key_press` to the first `key_repeat` (used only with AUTOREPEAT_EN).
- REPEAT_PERIOD, 5_000_000, cycles between subsequent `key_repeat` pulses (used only with AUTOREPEAT_EN).

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- key_raw  input  1  raw board key, asynchronous to clk, may bounce.
- key_level  output  1  debounced state; 1 = pressed.
- key_press  output  1  one-clk pulse on an accepted press.
- key_release  output  1  one-clk pulse on an accepted release.
- key_repeat  output  1  one-clk autorepeat pulse; constant 0 when AUTOREPEAT_EN is undefined.

Behaviour:
- Reset values:
  - key_level, key_press, key_release and key_repeat are 0.
  - FSM is in IDLE; all counters are 0.
  - Synchroniser flops hold the released level (1 if KEY_ACTIVE_LOW, else 0).
- Input path:
  - 2-flop synchroniser on key_raw, then polarity normalised to `p` (1 = pressed).
  - Nothing else samples key_raw.
- FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. Debounce counter db_cnt is `clog2(DB_CYCLES)` bits wide.
- IDLE:
  - p=1 → go to PRESS_WAIT, db_cnt=0.
- PRESS_WAIT:
  - p=0 → go to IDLE, db_cnt=0.
  - Otherwise db_cnt increments.
  - When db_cnt==DB_CYCLES-1 and p=1 → go to PRESSED in the same edge: key_level<=1, key_press<=1.
- PRESSED:
  - p=0 → go to RELEASE_WAIT, db_cnt=0.
- RELEASE_WAIT:
  - p=1 → go back to PRESSED, db_cnt=0, no pulse.
  - When db_cnt==DB_CYCLES-1 and p=0 → go to IDLE: key_level<=0, key_release<=1.
- Latency:
  - A clean edge on key_raw yields its pulse exactly DB_CYCLES+2 clk edges later.
  - A bounce interval shorter than DB_CYCLES produces no pulse.
- Pulse rules:
  - key_press and key_release are high for exactly one cycle and are never high in the same cycle.
  - key_level changes only in the cycle its pulse is high.
- Counter wrap: db_cnt never wraps; it is cleared on every abort.
- Key held across reset deassertion: IDLE sees p=1 → one key_press after DB_CYCLES+2 cycles. This is required behaviour.
- Reset mid-debounce or mid-hold: async clear to reset values; no release pulse is generated for the interrupted press.

Optional Feature:
- Macro: KEY_DEBOUNCE_AUTOREPEAT_EN.
- Defined:
  - In PRESSED, a rep_cnt counts hold cycles.
  - key_repeat pulses REPEAT_DELAY cycles after the key_press cycle, then every REPEAT_PERIOD cycles while in PRESSED.
  - rep_cnt clears on leaving PRESSED.
  - A PRESSED→RELEASE_WAIT→PRESSED bounce restarts the period count, not the delay.
  - key_repeat is never high in the same cycle as key_press.
- Undefined: rep_cnt logic is absent and key_repeat is tied to 0.

Decomposition:
- Package key_pkg:
  - state enum key_state_t {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT};
  - localparam defaults for DB_CYCLES, REPEAT_DELAY and REPEAT_PERIOD;
  - counter-width function.
- Sub-module sync_2ff:
  - parameterised reset value;
  - async active-low reset;
  - reused later for the sw0 direction switch.

Test Plan (DB_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5, KEY_ACTIVE_LOW=1):
- Reset: reset=0, key_raw=1 → all outputs 0. Release reset with key_raw=1 for 50 cycles → no pulses.
- Clean press: key_raw 1→0 and held → key_press high exactly 10 cycles after the edge for 1 cycle; key_level=1 from then on.
- Bounce: key_raw toggles every 3 cycles for 30 cycles, then stays 0 → exactly one key_press, 10 cycles after the last edge.
- Glitch: key_raw=0 for 5 cycles, then 1 → no key_press; key_level stays 0.
- Release with bounce: from PRESSED, key_raw=1 for 4 cycles, 0 for 2, then 1 held → single key_release 10 cycles after the final edge; key_level=0.
- Autorepeat (macro on): hold for 60 cycles after key_press → key_repeat at +20, +25, +30, …, +60. With the macro off, key_repeat stays 0 throughout. Assert reset mid-hold → outputs clear immediately and no key_release follows.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and defaults for the push-button conditioning path.
package key_pkg;

    // Debounce FSM states
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    localparam int unsigned DB_CYCLES_DEF     = 1_000_000;   // 20 ms at 50 MHz
    localparam int unsigned REPEAT_DELAY_DEF  = 25_000_000;
    localparam int unsigned REPEAT_PERIOD_DEF = 5_000_000;

    // Bits needed for a counter that runs 0..n-1 (at least one bit)
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level input.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Metastability filter; both stages reset to the idle level of the input
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Synchronises and debounces a board key; emits a clean level plus
// one-cycle press/release pulses. Optional autorepeat pulses are built
// when KEY_DEBOUNCE_AUTOREPEAT_EN is defined; otherwise key_repeat is 0.
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned DB_CYCLES      = DB_CYCLES_DEF,
    parameter bit          KEY_ACTIVE_LOW = 1'b1,
    parameter int unsigned REPEAT_DELAY   = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD  = REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_repeat
);

    localparam int unsigned     DB_W    = cnt_width(DB_CYCLES);
    localparam logic            REL_LVL = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    // Elaboration-time parameter sanity
    if ((DB_CYCLES < 2) || (DB_CYCLES > 32'h00FF_FFFF)) begin : g_bad_db
        $error("key_debounce: DB_CYCLES out of range 2..2^24-1");
    end
    if ((REPEAT_DELAY < 2) || (REPEAT_PERIOD < 1)) begin : g_bad_rep
        $error("key_debounce: REPEAT_DELAY must be >= 2 and REPEAT_PERIOD >= 1");
    end

    logic            key_sync;
    logic            key_p_c;
    key_state_t      state, state_n;
    logic [DB_W-1:0] db_cnt, db_cnt_n;
    logic            level_n, press_n, release_n;

    sync_2ff #(
        .RST_VAL (REL_LVL)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (key_raw),
        .q     (key_sync)
    );

    // Normalise polarity: 1 = pressed
    assign key_p_c = key_sync ^ KEY_ACTIVE_LOW;

    // State, debounce counter and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            db_cnt      <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            state       <= state_n;
            db_cnt      <= db_cnt_n;
            key_level   <= level_n;
            key_press   <= press_n;
            key_release <= release_n;
        end
    end

    // Next-state: a level change is accepted only after DB_CYCLES stable samples
    always_comb begin
        state_n   = state;
        db_cnt_n  = db_cnt;
        level_n   = key_level;
        press_n   = 1'b0;
        release_n = 1'b0;
        case (state)
            IDLE: begin
                if (key_p_c) begin
                    state_n  = PRESS_WAIT;
                    db_cnt_n = '0;
                end
            end
            PRESS_WAIT: begin
                if (!key_p_c) begin
                    state_n  = IDLE;
                    db_cnt_n = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_n  = PRESSED;
                    db_cnt_n = '0;
                    level_n  = 1'b1;
                    press_n  = 1'b1;
                end else begin
                    db_cnt_n = db_cnt + DB_W'(1);
                end
            end
            PRESSED: begin
                if (!key_p_c) begin
                    state_n  = RELEASE_WAIT;
                    db_cnt_n = '0;
                end
            end
            RELEASE_WAIT: begin
                if (key_p_c) begin
                    state_n  = PRESSED;
                    db_cnt_n = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_n   = IDLE;
                    db_cnt_n  = '0;
                    level_n   = 1'b0;
                    release_n = 1'b1;
                end else begin
                    db_cnt_n = db_cnt + DB_W'(1);
                end
            end
            default: begin
                state_n  = IDLE;
                db_cnt_n = '0;
            end
        endcase
    end

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned REP_W   = cnt_width(REP_MAX);
    localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    logic [REP_W-1:0] rep_cnt, rep_cnt_n;
    logic             delay_done, delay_done_n;
    logic             repeat_n;

    // Hold counter and autorepeat pulse register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rep_cnt    <= '0;
            delay_done <= 1'b0;
            key_repeat <= 1'b0;
        end else begin
            rep_cnt    <= rep_cnt_n;
            delay_done <= delay_done_n;
            key_repeat <= repeat_n;
        end
    end

    // First repeat after the delay, then one per period; a release bounce
    // re-enters PRESSED on the period rather than restarting the delay
    always_comb begin
        rep_cnt_n    = '0;
        delay_done_n = 1'b0;
        repeat_n     = 1'b0;
        case (state)
            PRESSED: begin
                if (state_n == PRESSED) begin
                    delay_done_n = delay_done;
                    if (!delay_done) begin
                        if (rep_cnt == REP_DELAY_LAST) begin
                            repeat_n     = 1'b1;
                            delay_done_n = 1'b1;
                        end else begin
                            rep_cnt_n = rep_cnt + REP_W'(1);
                        end
                    end else if (rep_cnt == REP_PERIOD_LAST) begin
                        repeat_n = 1'b1;
                    end else begin
                        rep_cnt_n = rep_cnt + REP_W'(1);
                    end
                end
            end
            RELEASE_WAIT: begin
                delay_done_n = 1'b1;
            end
            default: begin
                delay_done_n = 1'b0;
            end
        endcase
    end
`else
    assign key_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce (DB_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5).
module tb_key_debounce;

    localparam int unsigned DB  = 8;
    localparam int unsigned RD  = 20;
    localparam int unsigned RP  = 5;

    logic clk = 1'b0;
    logic reset;
    logic key_raw;
    logic key_level;
    logic key_press;
    logic key_release;
    logic key_repeat;

    int checks = 0;
    int errors = 0;

    // One phase: hold key_raw for n cycles; expected pulse offsets within the phase (-1 = none)
    typedef struct {
        logic raw;
        int   n;
        int   press_at;
        int   rel_at;
        logic level_end;
        int   rep_first;
        int   rep_n;
    } row_t;

    row_t rows[$];

    always #5 clk = ~clk;

    key_debounce #(
        .DB_CYCLES      (DB),
        .KEY_ACTIVE_LOW (1'b1),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_raw     (key_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_repeat  (key_repeat)
    );

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic row_t mk(input logic raw, input int n, input int press_at,
                                input int rel_at, input logic lvl,
                                input int rep_first, input int rep_n);
        row_t r;
        r.raw = raw; r.n = n; r.press_at = press_at; r.rel_at = rel_at;
        r.level_end = lvl; r.rep_first = rep_first; r.rep_n = rep_n;
        return r;
    endfunction

    task automatic check_all_zero(input string tag);
        check_int({tag, " key_level"},   int'(key_level),   0);
        check_int({tag, " key_press"},   int'(key_press),   0);
        check_int({tag, " key_release"}, int'(key_release), 0);
        check_int({tag, " key_repeat"},  int'(key_repeat),  0);
    endtask

    // Apply one phase starting at a negedge; sample each cycle at the following negedge
    task automatic run_row(input row_t r, input string tag);
        int   p_n = 0, p_first = -1;
        int   r_n = 0, r_first = -1;
        int   q_n = 0, q_first = -1, q_last = -1, gap_bad = 0;
        int   both = 0, lvl_bad = 0;
        logic prev_lvl;
        prev_lvl = key_level;
        for (int j = 0; j < r.n; j++) begin
            key_raw = r.raw;
            @(posedge clk);
            @(negedge clk);
            if (key_press) begin
                if (p_n == 0) p_first = j;
                p_n++;
            end
            if (key_release) begin
                if (r_n == 0) r_first = j;
                r_n++;
            end
            if (key_repeat) begin
                if (q_n == 0) q_first = j;
                else if ((j - q_last) != int'(RP)) gap_bad++;
                q_last = j;
                q_n++;
            end
            if ((key_press && key_release) || (key_press && key_repeat)) both++;
            if ((key_level != prev_lvl) && !(key_press || key_release)) lvl_bad++;
            if ((key_press && !key_level) || (key_release && key_level)) lvl_bad++;
            prev_lvl = key_level;
        end
        check_int({tag, " press_count"},   p_n,     (r.press_at < 0) ? 0 : 1);
        check_int({tag, " press_cycle"},   p_first, r.press_at);
        check_int({tag, " release_count"}, r_n,     (r.rel_at < 0) ? 0 : 1);
        check_int({tag, " release_cycle"}, r_first, r.rel_at);
        check_int({tag, " level_end"},     int'(key_level), int'(r.level_end));
        check_int({tag, " repeat_count"},  q_n,     r.rep_n);
        check_int({tag, " repeat_first"},  q_first, r.rep_first);
        check_int({tag, " repeat_gaps"},   gap_bad, 0);
        check_int({tag, " pulse_overlap"}, both,    0);
        check_int({tag, " level_rule"},    lvl_bad, 0);
    endtask

    initial begin
        row_t held;
        // Quiet, clean press, clean release, glitch
        rows.push_back(mk(1'b1, 50, -1, -1, 1'b0, -1, 0));
        rows.push_back(mk(1'b0, 20, 10, -1, 1'b1, -1, 0));
        rows.push_back(mk(1'b1, 20, -1, 10, 1'b0, -1, 0));
        rows.push_back(mk(1'b0,  5, -1, -1, 1'b0, -1, 0));
        rows.push_back(mk(1'b1, 20, -1, -1, 1'b0, -1, 0));
        // Bounce: toggle every 3 cycles for 30 cycles, then settle pressed
        for (int i = 0; i < 10; i++)
            rows.push_back(mk((i % 2 == 0) ? 1'b0 : 1'b1, 3, -1, -1, 1'b0, -1, 0));
        rows.push_back(mk(1'b0, 20, 10, -1, 1'b1, -1, 0));
        // Release with bounce
        rows.push_back(mk(1'b1,  4, -1, -1, 1'b1, -1, 0));
        rows.push_back(mk(1'b0,  2, -1, -1, 1'b1, -1, 0));
        rows.push_back(mk(1'b1, 20, -1, 10, 1'b0, -1, 0));
        // Long hold: press at +10, then 60 more cycles
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
        rows.push_back(mk(1'b0, 71, 10, -1, 1'b1, 10 + int'(RD), 9));
`else
        rows.push_back(mk(1'b0, 71, 10, -1, 1'b1, -1, 0));
`endif

        reset   = 1'b0;
        key_raw = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;

        for (int i = 0; i < rows.size(); i++)
            run_row(rows[i], $sformatf("row%0d", i));

        // Reset mid-hold: immediate clear, no release afterwards
        reset = 1'b0;
        #1;
        check_all_zero("midhold_reset");
        key_raw = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        run_row(mk(1'b1, 30, -1, -1, 1'b0, -1, 0), "after_midhold");

        // Key held across reset deassertion yields one press
        reset   = 1'b0;
        key_raw = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("held_reset");
        reset = 1'b1;
        held = mk(1'b0, 20, 10, -1, 1'b1, -1, 0);
        run_row(held, "held_through_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Run-time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
